// File: rtl/mem_defs.sv
// Memory access encodings shared by the decoder and the load/store unit.
package mem_defs;

  localparam logic [3:0] MT_X  = 4'd0;
  localparam logic [3:0] MT_B  = 4'd1;
  localparam logic [3:0] MT_H  = 4'd2;
  localparam logic [3:0] MT_W  = 4'd3;
  localparam logic [3:0] MT_BU = 4'd4;
  localparam logic [3:0] MT_HU = 4'd5;

  localparam logic [1:0] M_X = 2'd0;
  localparam logic [1:0] M_R = 2'd1;
  localparam logic [1:0] M_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Undefined codes are treated as illegal alongside the explicit X codes.
  function automatic logic illegal_req(
    input logic [3:0] mt,
    input logic [1:0] mw
  );
    logic bad_mw;
    logic bad_mt;
    bad_mw = (mw != M_R) && (mw != M_W);
    bad_mt = (mt == MT_X) || (mt > MT_HU);
    return bad_mw || bad_mt ||
           ((mw == M_W) && ((mt == MT_BU) || (mt == MT_HU)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane steering, load extraction/extension and alignment check.
module lsu_align
  import mem_defs::*;
(
  input  logic [3:0]  st_type,
  input  logic [1:0]  st_lo,
  input  logic [31:0] store_data,
  input  logic [3:0]  ld_type,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    wdata = '0;
    wstrb = '0;
    case (st_type)
      MT_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << st_lo;
      end
      MT_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {st_lo[1], 1'b0};
      end
      MT_W: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {ld_lo, 3'b000};

  always_comb begin
    load_data = '0;
    case (ld_type)
      MT_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MT_BU: load_data = {24'd0, shifted[7:0]};
      MT_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MT_HU: load_data = {16'd0, shifted[15:0]};
      MT_W:  load_data = shifted;
      default: ;
    endcase
  end

  assign misaligned =
    (((st_type == MT_H) || (st_type == MT_HU)) && st_lo[0]) ||
    ((st_type == MT_W) && (st_lo != 2'b00));

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: one aligned B/H/W access per request
// over a valid/ready bus, with fault classification.
module load_store_unit
  import mem_defs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            memory_type,
  input  logic [1:0]            memory_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t state, state_n;

  logic                  accept;
  logic                  capture;
  logic                  we_q;
  logic [3:0]            mt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           data_q;
  logic                  mis_q;
  logic                  fault_q;

  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_data;
  logic        st_mis;
  logic        illegal;
  logic        is_wr;

  lsu_align u_align (
    .st_type    (memory_type),
    .st_lo      (addr[1:0]),
    .store_data (store_data),
    .ld_type    (mt_q),
    .ld_lo      (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .load_data  (ld_data),
    .misaligned (st_mis)
  );

  assign illegal = illegal_req(memory_type, memory_write);
  assign is_wr   = (memory_write == M_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_n = (illegal || st_mis) ? RESP : REQ;
      end
      REQ:  if (mem_req_ready) state_n = WAIT;
      WAIT: if (mem_resp_valid) begin
        capture = 1'b1;
        state_n = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus fields are latched at accept so they stay stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      mt_q    <= MT_X;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (accept) begin
      we_q    <= is_wr;
      mt_q    <= memory_type;
      addr_q  <= addr;
      wdata_q <= is_wr ? st_wdata : 32'd0;
      wstrb_q <= is_wr ? st_wstrb : 4'd0;
      data_q  <= '0;
      mis_q   <= st_mis && !illegal;
      fault_q <= illegal;
    end else if (capture && !we_q) begin
      data_q  <= ld_data;
    end
  end

  assign req_ready     = (state == IDLE) && !rst;
  assign resp_valid    = (state == RESP);
  assign resp_data     = data_q;
  assign misaligned    = resp_valid && mis_q;
  assign access_fault  = resp_valid && fault_q;
  assign mem_req_valid = (state == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

endmodule
